// File: rtl/seg_pkg.sv
// Shared constants for the 8-digit multiplexed display path: glyph table, widths, polarity
// and the capture FSM state type.
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEG_W      = 8;
  localparam int DIG_W      = $clog2(NUM_DIGITS);
  localparam logic ANODE_ON = 1'b0;
  localparam logic SEG_ON   = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } cap_state_e;

  // Active-high {g,f,e,d,c,b,a}; identical to the table segment_controller drives from.
  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
  endfunction

endpackage

// File: rtl/segment_capture_if.sv
// Bundle between the observed display bus and the reconstructed frame outputs.
interface segment_capture_if;
  import seg_pkg::*;

  logic [NUM_DIGITS-1:0]   anodes;
  logic [SEG_W-1:0]        cathodes;
  logic [4*NUM_DIGITS-1:0] numb;
  logic [NUM_DIGITS-1:0]   mask;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    frame_valid;
  logic                    changed;
  logic                    err;
  cap_state_e              dbg_state;

  // frame_valid is a one-cycle strobe with no ready: numb/mask/dp/err/changed are valid from
  // that cycle and hold until the next strobe, so a consumer can never stall the capture.
  modport master (output anodes, cathodes,
                  input  numb, mask, dp, frame_valid, changed, err, dbg_state);
  modport slave  (input  anodes, cathodes,
                  output numb, mask, dp, frame_valid, changed, err, dbg_state);

endinterface

// File: rtl/seg_glyph_decoder.sv
// Maps an active-high 7-segment pattern back to its hex nibble; hit=0 for non-glyph patterns.
module seg_glyph_decoder
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       hit,
  output logic [3:0] nibble
);

  always_comb begin
    hit    = 1'b0;
    nibble = 4'h0;
    for (int n = 0; n < 16; n++) begin
      if (pattern == glyph(4'(n))) begin
        hit    = 1'b1;
        nibble = 4'(n);
      end
    end
  end

endmodule

// File: rtl/segment_capture.sv
// Reconstructs value, digit mask and error from an observed multiplexed display bus.
// Define SEGMENT_CAPTURE_DP_EN to capture decimal points into dp.
module segment_capture
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic              clk,
  input logic              rst_n,
  segment_capture_if.slave bus
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_MAX = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX     = TW'(TIMEOUT_CYCLES - 1);
  localparam int NW = 4 * NUM_DIGITS;

  logic [NUM_DIGITS-1:0] a_s1_q, a_s1_d, a_s2_q, a_s2_d;
  logic [SEG_W-1:0]      c_s1_q, c_s1_d, c_s2_q, c_s2_d;
  logic [NUM_DIGITS+SEG_W-1:0] pair_prev_q, pair_prev_d;
  logic [SW-1:0]         settle_q, settle_d;
  logic                  taken_q, taken_d;
  logic [TW-1:0]         to_q, to_d;
  cap_state_e            state_q, state_d;
  logic [NW-1:0]         numb_w_q, numb_w_d, numb_q, numb_d;
  logic [NUM_DIGITS-1:0] mask_w_q, mask_w_d, mask_q, mask_d;
  logic [NUM_DIGITS-1:0] dp_w_q, dp_w_d, dp_q, dp_d;
  logic                  err_w_q, err_w_d, err_q, err_d;
  logic [DIG_W-1:0]      first_q, first_d;
  logic                  pend_q, pend_d, pend_dp_q, pend_dp_d, pend_bad_q, pend_bad_d;
  logic [DIG_W-1:0]      pend_idx_q, pend_idx_d;
  logic [3:0]            pend_nib_q, pend_nib_d;
  logic                  fv_q, fv_d, chg_q, chg_d;

  logic [NUM_DIGITS-1:0] an_on;
  logic [6:0]            seg_on;
  logic                  seg_hit, dp_bit, pair_diff, stable, none_on, one_on;
  logic                  dig_evt, multi_evt, to_evt, others_seen;
  logic [3:0]            seg_nib;
  logic [DIG_W-1:0]      idx;
  logic                  wr_en, wr_dp, wr_bad;
  logic [DIG_W-1:0]      wr_idx;
  logic [3:0]            wr_nib;

  seg_glyph_decoder u_dec (.pattern(seg_on), .hit(seg_hit), .nibble(seg_nib));

  assign an_on     = a_s2_q ^ {NUM_DIGITS{~ANODE_ON}};
  assign seg_on    = c_s2_q[6:0] ^ {7{~SEG_ON}};
`ifdef SEGMENT_CAPTURE_DP_EN
  assign dp_bit    = c_s2_q[7] ^ ~SEG_ON;
`else
  assign dp_bit    = 1'b0;
`endif
  assign pair_diff = ({a_s2_q, c_s2_q} != pair_prev_q);
  assign stable    = !pair_diff && (settle_q == SETTLE_MAX);
  assign none_on   = (an_on == '0);
  assign one_on    = $onehot(an_on);
  // Each stable pair is acted on once; a long hold of the same digit is a single event.
  assign dig_evt   = stable && !taken_q && one_on;
  assign multi_evt = stable && !taken_q && !one_on && !none_on;
  assign to_evt    = none_on && (to_q == TO_MAX);
  assign others_seen = |(mask_w_q & ~(NUM_DIGITS'(1) << first_q));

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_on[i]) idx = DIG_W'(i);
    end
  end

  always_comb begin
    a_s1_d      = bus.anodes;
    a_s2_d      = a_s1_q;
    c_s1_d      = bus.cathodes;
    c_s2_d      = c_s1_q;
    pair_prev_d = {a_s2_q, c_s2_q};
    settle_d    = pair_diff ? '0 : ((settle_q == SETTLE_MAX) ? settle_q : settle_q + 1'b1);
    taken_d     = pair_diff ? 1'b0 : (taken_q | stable);
    to_d        = !none_on ? '0 : ((to_q == TO_MAX) ? to_q : to_q + 1'b1);
    state_d     = state_q;
    numb_w_d    = numb_w_q;
    mask_w_d    = mask_w_q;
    dp_w_d      = dp_w_q;
    err_w_d     = err_w_q;
    first_d     = first_q;
    pend_d      = pend_q;
    pend_idx_d  = pend_idx_q;
    pend_nib_d  = pend_nib_q;
    pend_dp_d   = pend_dp_q;
    pend_bad_d  = pend_bad_q;
    numb_d      = numb_q;
    mask_d      = mask_q;
    dp_d        = dp_q;
    err_d       = err_q;
    fv_d        = 1'b0;
    chg_d       = 1'b0;
    wr_en       = 1'b0;
    wr_idx      = idx;
    wr_nib      = seg_hit ? seg_nib : 4'h0;
    wr_dp       = dp_bit;
    wr_bad      = !seg_hit;

    case (state_q)
      ST_IDLE: begin
        if (dig_evt) begin
          wr_en   = 1'b1;
          first_d = idx;
          state_d = ST_CAPTURE;
        end else if (to_evt) begin
          to_d    = '0;
          state_d = ST_DONE;
        end
        if (multi_evt) err_w_d = 1'b1;
      end
      ST_CAPTURE: begin
        if (dig_evt) begin
          // Scan wrapped: park this digit so it seeds the next frame.
          if (idx <= first_q && others_seen) begin
            pend_d     = 1'b1;
            pend_idx_d = idx;
            pend_nib_d = wr_nib;
            pend_dp_d  = dp_bit;
            pend_bad_d = !seg_hit;
            state_d    = ST_DONE;
          end else begin
            wr_en = 1'b1;
          end
        end else if (to_evt) begin
          to_d    = '0;
          state_d = ST_DONE;
        end
        if (multi_evt) err_w_d = 1'b1;
      end
      default: begin
        numb_d   = numb_w_q;
        mask_d   = mask_w_q;
        dp_d     = dp_w_q;
        err_d    = err_w_q;
        fv_d     = 1'b1;
        chg_d    = ({numb_w_q, mask_w_q, dp_w_q} != {numb_q, mask_q, dp_q});
        numb_w_d = '0;
        mask_w_d = '0;
        dp_w_d   = '0;
        err_w_d  = 1'b0;
        state_d  = ST_IDLE;
        if (pend_q) begin
          wr_en   = 1'b1;
          wr_idx  = pend_idx_q;
          wr_nib  = pend_nib_q;
          wr_dp   = pend_dp_q;
          wr_bad  = pend_bad_q;
          first_d = pend_idx_q;
          pend_d  = 1'b0;
          state_d = ST_CAPTURE;
        end
      end
    endcase

    if (wr_en) begin
      numb_w_d[{wr_idx, 2'b00} +: 4] = wr_nib;
      mask_w_d[wr_idx] = 1'b1;
      dp_w_d[wr_idx]   = wr_dp;
      if (wr_bad) err_w_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_s1_q <= '1; a_s2_q <= '1; c_s1_q <= '1; c_s2_q <= '1;
      pair_prev_q <= '1;
      settle_q <= '0; taken_q <= 1'b0; to_q <= '0;
      state_q <= ST_IDLE;
      numb_w_q <= '0; mask_w_q <= '0; dp_w_q <= '0; err_w_q <= 1'b0;
      first_q <= '0;
      pend_q <= 1'b0; pend_idx_q <= '0; pend_nib_q <= '0; pend_dp_q <= 1'b0; pend_bad_q <= 1'b0;
      numb_q <= '0; mask_q <= '0; dp_q <= '0; err_q <= 1'b0;
      fv_q <= 1'b0; chg_q <= 1'b0;
    end else begin
      a_s1_q <= a_s1_d; a_s2_q <= a_s2_d; c_s1_q <= c_s1_d; c_s2_q <= c_s2_d;
      pair_prev_q <= pair_prev_d;
      settle_q <= settle_d; taken_q <= taken_d; to_q <= to_d;
      state_q <= state_d;
      numb_w_q <= numb_w_d; mask_w_q <= mask_w_d; dp_w_q <= dp_w_d; err_w_q <= err_w_d;
      first_q <= first_d;
      pend_q <= pend_d; pend_idx_q <= pend_idx_d; pend_nib_q <= pend_nib_d;
      pend_dp_q <= pend_dp_d; pend_bad_q <= pend_bad_d;
      numb_q <= numb_d; mask_q <= mask_d; dp_q <= dp_d; err_q <= err_d;
      fv_q <= fv_d; chg_q <= chg_d;
    end
  end

  assign bus.numb        = numb_q;
  assign bus.mask        = mask_q;
  assign bus.dp          = dp_q;
  assign bus.err         = err_q;
  assign bus.frame_valid = fv_q;
  assign bus.changed     = chg_q;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_segment_capture.sv
// Directed bench for segment_capture: scans frames onto the display bus and scoreboards
// every published frame against expectations pushed when each scan is driven.
module tb_segment_capture;
  import seg_pkg::*;

  localparam int TIMEOUT = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [49:0] exp_q[$];
  logic [47:0] last_pub = '0;

  segment_capture_if bus();
  segment_capture #(.STABLE_CYCLES(4), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [6:0] tb_glyph(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    return t[n];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_frame(input logic [31:0] n, input logic [7:0] m,
                                     input logic [7:0] d, input logic e);
    logic chg;
    chg = ({n, m, d} != last_pub);
    last_pub = {n, m, d};
    exp_q.push_back({n, m, d, e, chg});
  endfunction

  // Drives ndig digits of one scan, 8 cycles each, optionally preceded by a 1-cycle ghost.
  task automatic scan_frame(input logic [31:0] val, input logic [7:0] lit, input logic [7:0] dpm,
                            input int bad, input bit glitch, input int ndig);
    logic [7:0] a, c;
    for (int d = 0; d < ndig; d++) begin
      if (glitch) begin
        @(negedge clk);
        bus.anodes   = ~((8'b1 << d) | (8'b1 << ((d + 1) % 8)));
        bus.cathodes = 8'($urandom_range(0, 255));
      end
      a = lit[d] ? ~(8'b1 << d) : 8'hFF;
      c = {~dpm[d], ~tb_glyph(val[d*4 +: 4])};
      if (d == bad) c[6:0] = 7'h7F;
      @(negedge clk);
      bus.anodes   = a;
      bus.cathodes = c;
      repeat (7) @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    logic [49:0] e;
    if (rst_n && bus.frame_valid) begin
      check("frame_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("numb",    64'(bus.numb),    64'(e[49:18]));
        check("mask",    64'(bus.mask),    64'(e[17:10]));
        check("dp",      64'(bus.dp),      64'(e[9:2]));
        check("err",     64'(bus.err),     64'(e[1]));
        check("changed", 64'(bus.changed), 64'(e[0]));
      end
    end
  end

  initial begin
    logic [7:0] dp_exp;
`ifdef SEGMENT_CAPTURE_DP_EN
    dp_exp = 8'h41;
`else
    dp_exp = 8'h00;
`endif
    bus.anodes   = 8'hFF;
    bus.cathodes = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_numb",  64'(bus.numb),        64'd0);
    check("rst_mask",  64'(bus.mask),        64'd0);
    check("rst_dp",    64'(bus.dp),          64'd0);
    check("rst_fv",    64'(bus.frame_valid), 64'd0);
    check("rst_chg",   64'(bus.changed),     64'd0);
    check("rst_err",   64'(bus.err),         64'd0);
    check("rst_state", 64'(bus.dbg_state),   64'(ST_IDLE));
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Full value, three identical scans.
    for (int k = 0; k < 3; k++) begin
      push_frame(32'h1234_ABCD, 8'hFF, 8'h00, 1'b0);
      scan_frame(32'h1234_ABCD, 8'hFF, 8'h00, -1, 1'b0, 8);
    end
    // Digits 5..7 dark.
    for (int k = 0; k < 2; k++) begin
      push_frame(32'h0004_2E7F, 8'h1F, 8'h00, 1'b0);
      scan_frame(32'h0004_2E7F, 8'h1F, 8'h00, -1, 1'b0, 8);
    end
    // Ghost patterns between digits must be ignored.
    for (int k = 0; k < 2; k++) begin
      push_frame(32'h1234_ABCD, 8'hFF, 8'h00, 1'b0);
      scan_frame(32'h1234_ABCD, 8'hFF, 8'h00, -1, 1'b1, 8);
    end
    // Blank glyph on digit 3.
    push_frame(32'h1234_0BCD, 8'hFF, 8'h00, 1'b1);
    scan_frame(32'h1234_ABCD, 8'hFF, 8'h00, 3, 1'b0, 8);

    // Reset while digit 4 of the next scan is on the bus.
    scan_frame(32'h1234_ABCD, 8'hFF, 8'h00, -1, 1'b0, 4);
    @(negedge clk);
    bus.anodes   = ~8'h10;
    bus.cathodes = {1'b1, ~tb_glyph(4'h4)};
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_numb",  64'(bus.numb),        64'd0);
    check("arst_mask",  64'(bus.mask),        64'd0);
    check("arst_err",   64'(bus.err),         64'd0);
    check("arst_fv",    64'(bus.frame_valid), 64'd0);
    check("arst_state", 64'(bus.dbg_state),   64'(ST_IDLE));
    bus.anodes   = 8'hFF;
    bus.cathodes = 8'hFF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_pub = '0;
    repeat (10) @(negedge clk);
    check("post_rst_q", 64'(exp_q.size()), 64'd0);

    for (int k = 0; k < 2; k++) begin
      push_frame(32'h8765_4321, 8'hFF, 8'h00, 1'b0);
      scan_frame(32'h8765_4321, 8'hFF, 8'h00, -1, 1'b0, 8);
    end
    // Decimal points on digits 0 and 6.
    push_frame(32'h8765_4321, 8'hFF, dp_exp, 1'b0);
    scan_frame(32'h8765_4321, 8'hFF, 8'h41, -1, 1'b0, 8);

    // Idle bus: last scan flushes on timeout, then one blank frame.
    push_frame(32'h0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    bus.anodes   = 8'hFF;
    bus.cathodes = 8'hFF;
    repeat (2 * TIMEOUT + 100) @(negedge clk);

    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
